// File: rtl/data_memory_responder_pkg.sv
// mem_pkg: shared types and constants for the data-memory responder.
//   mem_state_t     - responder FSM states (IDLE, BUSY, RESPOND)
//   MEM_LATENCY     - default request-to-response latency in cycles
//   WORD_W          - storage word width in bits
//   byte_lane_mask  - 4-bit byte write enable for a word or single-byte access
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } mem_state_t;

  localparam int MEM_LATENCY = 4;
  localparam int WORD_W      = 32;

  // Word accesses enable every lane regardless of the low address bits.
  function automatic logic [3:0] byte_lane_mask(input logic [1:0] lane,
                                                input logic       is_word);
    logic [3:0] mask;
    mask = 4'b0001 << lane;
    if (is_word) begin
      mask = 4'hF;
    end
    return mask;
  endfunction

endpackage

// File: rtl/data_memory_responder_sram.sv
// sram_byte_array: DEPTH x 32-bit storage with byte-lane write enables
// and a registered read port. Contents are not reset; only the read
// register is.
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset (read register only)
//   we     - per-byte write enable, lane 0 = bits [7:0]
//   re     - capture mem[idx] into rdata at this edge
//   idx    - word index
//   wdata  - write data, lane-aligned
//   rdata  - registered read data
module sram_byte_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: slow backing store behind the data cache.
// Accepts one word/byte read or write at a time, commits it LATENCY
// cycles after acceptance and raises rsp_valid for one cycle.
//   clk         - clock, rising edge
//   reset       - asynchronous active-high reset
//   req_valid   - request present (must be held until req_ready)
//   req_write   - 1 = write, 0 = read
//   req_is_word - 1 = 32-bit access, 0 = byte access
//   req_addr    - byte address; wraps modulo DEPTH words
//   req_wdata   - write data; byte writes use bits [7:0]
//   req_ready   - request accepted this cycle if req_valid
//   rsp_valid   - single-cycle completion strobe
//   rsp_rdata   - read data; held until the next read completes
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = MEM_LATENCY,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic              req_is_word,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt;

  logic              lat_write;
  logic              lat_is_word;
  logic [IDX_W-1:0]  lat_idx;
  logic [1:0]        lat_lane;
  logic [WORD_W-1:0] lat_wdata;

  // Format of the most recent read; kept separately from the request
  // latch so rsp_rdata stays stable once a new request is accepted.
  logic              fmt_is_word;
  logic [1:0]        fmt_lane;

  logic              accept;
  logic              commit;
  logic [3:0]        sram_we;
  logic              sram_re;
  logic [WORD_W-1:0] sram_wdata;
  logic [WORD_W-1:0] sram_rdata;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:IDX_W+2];

  assign accept = req_valid & req_ready;
  assign commit = (state == BUSY) && (cnt == '0);

  always_comb begin
    state_next = state;
    req_ready  = 1'b1;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_next = BUSY;
      end
      BUSY: begin
        req_ready = 1'b0;
        if (cnt == '0) state_next = RESPOND;
      end
      RESPOND: begin
        rsp_valid  = 1'b1;
        state_next = req_valid ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_write   <= 1'b0;
      lat_is_word <= 1'b0;
      lat_idx     <= '0;
      lat_lane    <= '0;
      lat_wdata   <= '0;
      fmt_is_word <= 1'b1;
      fmt_lane    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt         <= CNT_LOAD;
        lat_write   <= req_write;
        lat_is_word <= req_is_word;
        lat_idx     <= req_addr[IDX_W+1:2];
        lat_lane    <= req_addr[1:0];
        lat_wdata   <= req_wdata;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit && !lat_write) begin
        fmt_is_word <= lat_is_word;
        fmt_lane    <= lat_lane;
      end
    end
  end

  // Byte writes replicate the byte to every lane; the mask picks one.
  always_comb begin
    sram_we    = '0;
    sram_re    = commit & ~lat_write;
    sram_wdata = lat_is_word ? lat_wdata : {4{lat_wdata[7:0]}};
    if (commit && lat_write) begin
      sram_we = byte_lane_mask(lat_lane, lat_is_word);
    end
  end

  sram_byte_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_sram (
    .clk   (clk),
    .reset (reset),
    .we    (sram_we),
    .re    (sram_re),
    .idx   (lat_idx),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  always_comb begin
    rsp_rdata = sram_rdata;
    if (!fmt_is_word) begin
      case (fmt_lane)
        2'd0:    rsp_rdata = {24'b0, sram_rdata[7:0]};
        2'd1:    rsp_rdata = {24'b0, sram_rdata[15:8]};
        2'd2:    rsp_rdata = {24'b0, sram_rdata[23:16]};
        default: rsp_rdata = {24'b0, sram_rdata[31:24]};
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (DEPTH=1024, LATENCY=4).
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic        req_is_word;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_responder #(
    .DEPTH   (1024),
    .LATENCY (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_is_word (req_is_word),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata)
  );

  typedef struct {
    logic        w;
    logic        iw;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one request, waits for acceptance, then returns the
  // response data and the number of edges from acceptance to response.
  task automatic issue(input logic w, input logic iw, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output int lat);
    int n;
    bit got;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_is_word = iw; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 1; got = 0; lat = -1; rd = '0;
    while (n <= 20 && !got) begin
      if (rsp_valid) begin
        got = 1; lat = n - 1; rd = rsp_rdata;
      end else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] last_rd;
    int          lat;
    int          n;
    int          k;
    int          t[2];
    logic [31:0] bd[2];
    int          ready_bad;
    int          rsp_seen;

    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0102_0304, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0080, 32'h1122_3344, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0082, 32'hFFFF_FFAA, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0080, 32'h0,         32'h11AA_3344};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_0083, 32'h0,         32'h0000_0011};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,         32'h0000_0044};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,         32'hCAFE_F00D};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0043, 32'h0,         32'hDEAD_BEEF};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'h0102_0304};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_is_word = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'h0);

    last_rd = 32'h0;
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].w, vecs[i].iw, vecs[i].a, vecs[i].d, rd, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      if (vecs[i].w) begin
        check($sformatf("vec%0d_rdata_held", i), rd, last_rd);
      end else begin
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        last_rd = vecs[i].exp;
      end
    end

    // Back-to-back: write then read of the same word, second request
    // held through BUSY and accepted in the RESPOND cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_is_word = 1'b1;
    req_addr = 32'h200; req_wdata = 32'h1234_5678;
    @(negedge clk);
    n = 1; k = 0; t[0] = 0; t[1] = 0; bd[0] = '0; bd[1] = '0;
    req_write = 1'b0; req_wdata = '0;
    check("b2b_busy_ready", {31'b0, req_ready}, 32'd0);
    while (n < 30 && k < 2) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        t[k] = n; bd[k] = rsp_rdata; k++;
      end else if (k == 1 && req_valid) begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_responses", 32'(k), 32'd2);
    check("b2b_first_time", 32'(t[0]), 32'd5);
    check("b2b_spacing", 32'(t[1] - t[0]), 32'd5);
    check("b2b_raw_data", bd[1], 32'h1234_5678);
    @(negedge clk);

    // BUSY ignores requests: change the presented request while busy.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_is_word = 1'b1;
    req_addr = 32'h40; req_wdata = '0;
    @(negedge clk);
    n = 1; ready_bad = 0; lat = -1; rd = '0;
    while (n <= 20) begin
      if (rsp_valid) begin
        lat = n - 1; rd = rsp_rdata; req_valid = 1'b0;
        break;
      end
      if (req_ready) ready_bad++;
      req_write = 1'b1; req_is_word = 1'b1;
      req_addr = 32'h80 + 32'(n * 4); req_wdata = 32'hBAD0_0000 + 32'(n);
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    check("busy_ready_low", 32'(ready_bad), 32'd0);
    check("busy_latency", 32'(lat), 32'd4);
    check("busy_rdata", rd, 32'hDEAD_BEEF);
    issue(1'b0, 1'b1, 32'h84, 32'h0, rd, lat);
    check("busy_no_write_84", (rd === 32'hBAD0_0001) ? 32'd1 : 32'd0, 32'd0);
    issue(1'b0, 1'b1, 32'h80, 32'h0, rd, lat);
    check("busy_80_intact", rd, 32'h11AA_3344);

    // Reset two cycles into a write of 0x55 to 0x10.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_is_word = 1'b1;
    req_addr = 32'h10; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_mid_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rsp_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    check("rst_mid_no_rsp", 32'(rsp_seen), 32'd0);
    issue(1'b0, 1'b1, 32'h10, 32'h0, rd, lat);
    check("rst_mid_latency", 32'(lat), 32'd4);
    check("rst_mid_not_committed", rd, 32'h0102_0304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
